lif_neuron_array: RTL and testbench

Time-multiplexed array of NUM_NEURONS leaky integrate-and-fire neurons sharing one update datapath. Weighted input events accumulate into per-neuron current accumulators. Each global tick sweeps all neurons, one per cycle, applying leak, integration, threshold, reset and refractory behaviour. It replaces the single-neuron block in larger SNN layers and adds a selectable exponential-leak mode and a spike event stream.

---
 rtl/lif_neuron_array.sv | 180 ++++++++++++++++++
 tb/tb_lif_neuron_array.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons.
// One shared datapath visits every neuron once per global tick, one neuron
// per clock, applying leak, integration, threshold, reset and refractory
// hold. Input events are folded into per-neuron saturating accumulators
// while the array is idle.
module lif_neuron_array #(
   parameter int WIDTH             = 16,
   parameter int NUM_NEURONS       = 8,
   parameter int THRESHOLD         = 1000,
   parameter int LEAK              = 10,
   parameter int LEAK_SHIFT        = 4,
   parameter int LEAK_MODE         = 0,
   parameter int RESET_POTENTIAL   = 0,
   parameter int REFRACTORY_CYCLES = 10,
   localparam int IDX_W            = $clog2(NUM_NEURONS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [IDX_W-1:0]        in_idx,
   input  logic signed [WIDTH-1:0] in_weight,
   input  logic                    tick,
   output logic                    busy,
   output logic                    spike_valid,
   output logic [IDX_W-1:0]        spike_idx,
   output logic                    tick_overrun
);

   // Two guard bits let v - leak + acc be formed without any wrap-around.
   localparam int SUM_W = WIDTH + 2;
   localparam int REF_W = (REFRACTORY_CYCLES > 0) ? $clog2(REFRACTORY_CYCLES + 1) : 1;

   localparam logic signed [SUM_W-1:0] MAX_S = {3'b000, {(WIDTH-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] MIN_S = {3'b111, {(WIDTH-1){1'b0}}};

   localparam logic signed [WIDTH-1:0] THRESH_W  = WIDTH'(THRESHOLD);
   localparam logic signed [WIDTH-1:0] RESET_W   = WIDTH'(RESET_POTENTIAL);
   localparam logic [REF_W-1:0]        REFR_W    = REF_W'(REFRACTORY_CYCLES);
   localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(NUM_NEURONS - 1);

   typedef enum logic {
      IDLE,
      SWEEP
   } state_t;

   state_t r_state;
   state_t w_nextState;

   logic signed [WIDTH-1:0] r_pot [NUM_NEURONS];
   logic signed [WIDTH-1:0] r_acc [NUM_NEURONS];
   logic [REF_W-1:0]        r_ref [NUM_NEURONS];
   logic [IDX_W-1:0]        r_ptr;
   logic                    r_spikeValid;
   logic [IDX_W-1:0]        r_spikeIdx;
   logic                    r_tickOverrun;

   logic signed [WIDTH-1:0] w_curPot;
   logic signed [WIDTH-1:0] w_curAcc;
   logic [REF_W-1:0]        w_curRef;
   logic signed [SUM_W-1:0] w_leak;
   logic signed [SUM_W-1:0] w_sum;
   logic signed [WIDTH-1:0] w_newPot;
   logic                    w_fire;
   logic signed [WIDTH-1:0] w_inAcc;
   logic signed [SUM_W-1:0] w_inSum;
   logic                    w_idxValid;

   // Clamp a wide intermediate back into the signed WIDTH range.
   function automatic logic signed [WIDTH-1:0] satW(input logic signed [SUM_W-1:0] x);
      if (x > MAX_S) begin
         return MAX_S[WIDTH-1:0];
      end else if (x < MIN_S) begin
         return MIN_S[WIDTH-1:0];
      end
      return x[WIDTH-1:0];
   endfunction

   assign w_curPot   = r_pot[r_ptr];
   assign w_curAcc   = r_acc[r_ptr];
   assign w_curRef   = r_ref[r_ptr];
   assign w_inAcc    = r_acc[in_idx];
   assign w_inSum    = SUM_W'(w_inAcc) + SUM_W'(in_weight);
   assign w_idxValid = (int'(in_idx) < NUM_NEURONS);

   // Leak term for the neuron under the pointer: fixed step or arithmetic shift.
   always_comb begin
      w_leak = SUM_W'(LEAK);
      if (LEAK_MODE != 0) begin
         w_leak = SUM_W'(w_curPot >>> LEAK_SHIFT);
      end
   end

   assign w_sum    = SUM_W'(w_curPot) - w_leak + SUM_W'(w_curAcc);
   assign w_newPot = satW(w_sum);
   assign w_fire   = (w_newPot >= THRESH_W);

   // State register for the idle/sweep controller.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and handshake outputs: a tick starts a sweep, the last neuron ends it.
   always_comb begin
      w_nextState = r_state;
      in_ready    = 1'b0;
      busy        = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (tick) begin
               w_nextState = SWEEP;
            end
         end
         SWEEP: begin
            busy = 1'b1;
            if (r_ptr == LAST_IDX) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Neuron state: accumulate events while idle, update one neuron per cycle while sweeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_NEURONS; i++) begin
            r_pot[i] <= '0;
            r_acc[i] <= '0;
            r_ref[i] <= '0;
         end
         r_ptr         <= '0;
         r_spikeValid  <= 1'b0;
         r_spikeIdx    <= '0;
         r_tickOverrun <= 1'b0;
      end else begin
         r_spikeValid <= 1'b0;
         case (r_state)
            IDLE: begin
               r_ptr <= '0;
               if (in_valid && w_idxValid) begin
                  r_acc[in_idx] <= satW(w_inSum);
               end
            end
            SWEEP: begin
               if (tick) begin
                  r_tickOverrun <= 1'b1;
               end
               r_acc[r_ptr] <= '0;
               if (w_curRef != '0) begin
                  r_ref[r_ptr] <= w_curRef - 1'b1;
               end else if (w_fire) begin
                  r_pot[r_ptr] <= RESET_W;
                  r_ref[r_ptr] <= REFR_W;
                  r_spikeValid <= 1'b1;
                  r_spikeIdx   <= r_ptr;
               end else begin
                  r_pot[r_ptr] <= w_newPot;
               end
               if (r_ptr == LAST_IDX) begin
                  r_ptr <= '0;
               end else begin
                  r_ptr <= r_ptr + 1'b1;
               end
            end
            default: r_ptr <= '0;
         endcase
      end
   end

   assign spike_valid  = r_spikeValid;
   assign spike_idx    = r_spikeIdx;
   assign tick_overrun = r_tickOverrun;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Testbench for lif_neuron_array: a linear-leak and an exponential-leak
// instance share one stimulus stream and are checked every cycle against a
// tick-level behavioural model of the neuron array.
module tb_lif_neuron_array;

   localparam int W     = 16;
   localparam int N     = 8;
   localparam int TH    = 1000;
   localparam int LEAKV = 10;
   localparam int SH    = 4;
   localparam int RESP  = 0;
   localparam int REFR  = 10;

   logic               clk;
   logic               rst;
   logic               inValid;
   logic [2:0]         inIdx;
   logic signed [W-1:0] inWeight;
   logic               tick;

   logic       inReady [2];
   logic       busy [2];
   logic       spikeValid [2];
   logic [2:0] spikeIdx [2];
   logic       overrun [2];

   int errors = 0;
   int checks = 0;

   lif_neuron_array #(.LEAK_MODE(0)) dutLinear (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady[0]),
      .in_idx(inIdx), .in_weight(inWeight), .tick(tick), .busy(busy[0]),
      .spike_valid(spikeValid[0]), .spike_idx(spikeIdx[0]), .tick_overrun(overrun[0])
   );

   lif_neuron_array #(.LEAK_MODE(1)) dutExp (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady[1]),
      .in_idx(inIdx), .in_weight(inWeight), .tick(tick), .busy(busy[1]),
      .spike_valid(spikeValid[1]), .spike_idx(spikeIdx[1]), .tick_overrun(overrun[1])
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports failures
   task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, $signed(actual), expected);
      end
   endtask

   // ---------------- behavioural model ----------------
   int  pot [2][N];
   int  refc [2][N];
   int  acc [N];
   bit  fireMask [2][N];
   int  sweepPos = -1;
   int  edgeCount = 0;
   bit  modelValid = 0;
   bit  mOverrun;
   bit  expSpV [2];
   int  expSpIdx [2];

   function automatic int satW(input int x);
      if (x > 32767) return 32767;
      if (x < -32768) return -32768;
      return x;
   endfunction

   // One timestep of neuron i under leak mode m; returns 1 on a spike
   function automatic bit stepNeuron(input int m, input int i);
      int leak;
      int s;
      if (refc[m][i] != 0) begin
         refc[m][i]--;
         return 1'b0;
      end
      leak = (m == 0) ? LEAKV : (pot[m][i] >>> SH);
      s = satW(pot[m][i] - leak + acc[i]);
      if (s >= TH) begin
         pot[m][i]  = RESP;
         refc[m][i] = REFR;
         return 1'b1;
      end
      pot[m][i] = s;
      return 1'b0;
   endfunction

   // Model advances at each rising edge: the whole tick is resolved at once,
   // and its spikes are then released one neuron per cycle.
   always @(posedge clk) begin
      edgeCount++;
      if (rst) begin
         for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < N; i++) begin
               pot[m][i] = 0;
               refc[m][i] = 0;
               fireMask[m][i] = 0;
            end
            expSpV[m] = 0;
            expSpIdx[m] = 0;
         end
         for (int i = 0; i < N; i++) acc[i] = 0;
         sweepPos = -1;
         mOverrun = 0;
         modelValid = 1;
      end else begin
         expSpV[0] = 0;
         expSpV[1] = 0;
         if (sweepPos >= 0) begin
            if (tick) mOverrun = 1;
            for (int m = 0; m < 2; m++) begin
               if (fireMask[m][sweepPos]) begin
                  expSpV[m] = 1;
                  expSpIdx[m] = sweepPos;
               end
            end
            sweepPos++;
            if (sweepPos == N) sweepPos = -1;
         end else begin
            if (inValid && int'(inIdx) < N) acc[inIdx] = satW(acc[inIdx] + int'(inWeight));
            if (tick) begin
               for (int m = 0; m < 2; m++)
                  for (int i = 0; i < N; i++)
                     fireMask[m][i] = stepNeuron(m, i);
               for (int i = 0; i < N; i++) acc[i] = 0;
               sweepPos = 0;
            end
         end
      end
   end

   // Compare process: all DUT outputs against the model on every cycle after reset
   always @(negedge clk) begin
      if (modelValid) begin
         for (int m = 0; m < 2; m++) begin
            checkOutput($sformatf("busy[%0d]", m), busy[m], (sweepPos >= 0) ? 1 : 0);
            checkOutput($sformatf("in_ready[%0d]", m), inReady[m], (sweepPos >= 0) ? 0 : 1);
            checkOutput($sformatf("spike_valid[%0d]", m), spikeValid[m], expSpV[m]);
            checkOutput($sformatf("tick_overrun[%0d]", m), overrun[m], mOverrun);
            if (expSpV[m]) checkOutput($sformatf("spike_idx[%0d]", m), spikeIdx[m], expSpIdx[m]);
         end
      end
   end

   // Spike observer used by the directed literal checks
   int spikeCount [2] = '{0, 0};
   int lastSpikeIdx [2];
   int lastSpikeEdge [2];
   always @(negedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (spikeValid[m] === 1'b1) begin
            spikeCount[m]++;
            lastSpikeIdx[m] = spikeIdx[m];
            lastSpikeEdge[m] = edgeCount;
         end
      end
   end

   // Drive one cycle of inputs, changed on the falling edge
   task automatic applyStimulus(input bit v, input int idx, input int w, input bit t);
      @(negedge clk);
      inValid  = v;
      inIdx    = idx[2:0];
      inWeight = w[W-1:0];
      tick     = t;
   endtask

   task automatic runIdle(input int n);
      repeat (n) applyStimulus(0, 0, 0, 0);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      inValid = 0; tick = 0; inIdx = 0; inWeight = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Watchdog keeps the run bounded whatever the DUT does
   initial begin
      #2000000;
      errors++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   int base0;
   int base1;
   int tickEdge;
   int notReady;
   bit accepted;
   int expPot [5] = '{900, 994, 942, 964, 0};
   int wSeq [5]   = '{900, 150, 10, 80, 100};

   initial begin
      rst = 1'b1; inValid = 0; tick = 0; inIdx = 0; inWeight = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checkOutput("reset in_ready", inReady[0], 1);
      checkOutput("reset busy", busy[0], 0);
      checkOutput("reset spike_idx", spikeIdx[0], 0);

      // Single event crossing threshold: one spike from neuron 3, 4 edges after the tick edge
      $display("[TB] single spike latency");
      doReset();
      applyStimulus(1, 3, 1010, 0);
      base0 = spikeCount[0];
      applyStimulus(0, 0, 0, 1);
      tickEdge = edgeCount + 1;
      runIdle(12);
      checkOutput("latency spike count", spikeCount[0] - base0, 1);
      checkOutput("latency spike idx", lastSpikeIdx[0], 3);
      checkOutput("latency tick to spike", lastSpikeEdge[0] - tickEdge, 4);

      // Refractory: strong drive every tick only spikes on ticks 1, 12 and 23
      $display("[TB] refractory period");
      doReset();
      for (int k = 1; k <= 23; k++) begin
         applyStimulus(1, 3, 2000, 0);
         base0 = spikeCount[0];
         applyStimulus(0, 0, 0, 1);
         runIdle(11);
         checkOutput($sformatf("refractory tick %0d", k), spikeCount[0] - base0,
                     (k == 1 || k == 12 || k == 23) ? 1 : 0);
      end

      // Saturation of accumulator and potential
      $display("[TB] saturation");
      doReset();
      applyStimulus(1, 0, -32768, 0);
      applyStimulus(1, 0, -32768, 0);
      base0 = spikeCount[0];
      applyStimulus(0, 0, 0, 1);
      runIdle(11);
      checkOutput("sat negative no spike", spikeCount[0] - base0, 0);
      checkOutput("sat model potential clamp", pot[0][0], -32768);
      base0 = spikeCount[0];
      applyStimulus(1, 0, 1010, 1);
      runIdle(11);
      checkOutput("sat no wrap spike", spikeCount[0] - base0, 0);
      doReset();
      applyStimulus(1, 0, 32767, 0);
      applyStimulus(1, 0, 32767, 0);
      base0 = spikeCount[0];
      applyStimulus(0, 0, 0, 1);
      runIdle(11);
      checkOutput("sat positive spike", spikeCount[0] - base0, 1);

      // Exponential leak sequence on neuron 2
      $display("[TB] exponential leak");
      doReset();
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1, 2, wSeq[k], 0);
         base1 = spikeCount[1];
         applyStimulus(0, 0, 0, 1);
         runIdle(11);
         checkOutput($sformatf("exp leak model v step %0d", k), pot[1][2], expPot[k]);
         checkOutput($sformatf("exp leak spike step %0d", k), spikeCount[1] - base1, (k == 4) ? 1 : 0);
      end

      // Tick overrun and back-pressure while sweeping
      $display("[TB] overrun and in_ready");
      doReset();
      applyStimulus(1, 5, 300, 0);
      applyStimulus(0, 0, 0, 1);
      notReady = 0;
      accepted = 0;
      for (int c = 0; c < 20 && !accepted; c++) begin
         @(negedge clk);
         inValid = 1; inIdx = 3'd1; inWeight = 16'sd1200; tick = (c == 2);
         if (inReady[0]) accepted = 1;
         else notReady++;
      end
      if (!accepted) $display("[TB] FAIL overrun accept: event never accepted within bound");
      checkOutput("overrun accepted", accepted, 1);
      checkOutput("overrun not-ready cycles", notReady, 8);
      runIdle(3);
      checkOutput("overrun sticky", overrun[0], 1);
      base0 = spikeCount[0];
      applyStimulus(0, 0, 0, 1);
      runIdle(11);
      checkOutput("held event spike count", spikeCount[0] - base0, 1);
      checkOutput("held event spike idx", lastSpikeIdx[0], 1);
      checkOutput("overrun still set", overrun[0], 1);

      // Reset in the middle of a sweep suppresses pending spikes
      $display("[TB] reset mid-sweep");
      doReset();
      applyStimulus(1, 4, 1010, 0);
      applyStimulus(1, 6, 1010, 0);
      base0 = spikeCount[0];
      applyStimulus(0, 0, 0, 1);
      runIdle(2);
      @(negedge clk);
      rst = 1'b1; inValid = 0; tick = 0;
      @(negedge clk);
      rst = 1'b0;
      runIdle(12);
      checkOutput("mid-sweep reset spikes", spikeCount[0] - base0, 0);
      applyStimulus(0, 0, 0, 1);
      runIdle(11);
      checkOutput("post reset tick spikes", spikeCount[0] - base0, 0);
      for (int i = 0; i < N; i++)
         checkOutput($sformatf("post reset model v[%0d]", i), pot[0][i], -10);

      // Randomised traffic checked by the model every cycle
      $display("[TB] random traffic");
      doReset();
      for (int c = 0; c < 3000; c++) begin
         int r;
         int w;
         r = $urandom_range(0, 9);
         if (r == 0) w = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
         else w = $urandom_range(0, 500) - 150;
         @(negedge clk);
         rst      = ($urandom_range(0, 499) == 0);
         inValid  = $urandom_range(0, 1);
         inIdx    = 3'($urandom_range(0, N - 1));
         inWeight = w[W-1:0];
         tick     = ($urandom_range(0, 9) == 0);
      end
      @(negedge clk);
      rst = 1'b0; inValid = 0; tick = 0;
      runIdle(12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
